// File: rtl/dma_pkg.sv
// Shared AXI constants and write-engine state encoding for the DMA blocks.
package dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, AW, W, B} wr_state_t;

endpackage

// File: rtl/axi_dma_write_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DMA write engine and memory.
interface axi_dma_write_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_dma_write.sv
// DMA write engine: drains a FWFT FIFO into fixed-length AXI4 INCR bursts,
// one burst outstanding at a time, with done pulse and sticky error.
module axi_dma_write
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [15:0]           xfer_bursts,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  axi_dma_write_if.master       axi
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));

  wr_state_t             r_state;
  wr_state_t             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_remaining;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_done;
  logic                  r_error;

  logic w_start_ok;
  logic w_awvalid;
  logic w_wvalid;
  logic w_bready;
  logic w_w_hs;
  logic w_b_hs;
  logic w_resp_err;
  logic w_last_beat;
  logic w_last_burst;

  assign w_start_ok   = (r_state == IDLE) && start;
  assign w_resp_err   = (axi.bresp == AXI_RESP_SLVERR) || (axi.bresp == AXI_RESP_DECERR);
  assign w_last_beat  = (r_beat == LAST_BEAT);
  assign w_last_burst = (r_remaining == 16'd1);
  assign w_w_hs       = w_wvalid && axi.wready;
  assign w_b_hs       = w_bready && axi.bvalid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // wvalid follows FIFO occupancy only, so a slave may wait on wvalid before raising wready.
  always_comb begin
    w_state_nxt = r_state;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_bready    = 1'b0;
    case (r_state)
      IDLE: if (start && (xfer_bursts != 16'd0)) w_state_nxt = AW;
      AW: begin
        w_awvalid = 1'b1;
        if (axi.awready) w_state_nxt = W;
      end
      W: begin
        w_wvalid = !fifo_empty;
        if (w_wvalid && axi.wready && w_last_beat) w_state_nxt = B;
      end
      B: begin
        w_bready = 1'b1;
        if (axi.bvalid) w_state_nxt = (w_resp_err || w_last_burst) ? IDLE : AW;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_beat      <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_addr      <= dst_addr;
        r_remaining <= xfer_bursts;
        r_beat      <= '0;
        r_error     <= 1'b0;
        r_done      <= (xfer_bursts == 16'd0);
      end
      if (w_w_hs) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      // An error response ends the job at once; the address is left at the failed burst.
      if (w_b_hs) begin
        if (w_resp_err) begin
          r_error <= 1'b1;
          r_done  <= 1'b1;
        end else begin
          r_addr      <= r_addr + BURST_BYTES;
          r_remaining <= r_remaining - 16'd1;
          r_done      <= w_last_burst;
        end
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign error       = r_error;
  assign fifo_rd_en  = w_w_hs;

  assign axi.awaddr  = r_addr;
  assign axi.awlen   = 8'(BURST_LEN - 1);
  assign axi.awsize  = 3'($clog2(DATA_WIDTH / 8));
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awvalid = w_awvalid;
  assign axi.wdata   = fifo_rd_data;
  assign axi.wstrb   = '1;
  assign axi.wlast   = w_wvalid && w_last_beat;
  assign axi.wvalid  = w_wvalid;
  assign axi.bready  = w_bready;

endmodule

// File: tb/tb_axi_dma_write.sv
// Scoreboard bench for axi_dma_write: jobs push expected AW/W/done items; a
// negedge monitor pops and compares whatever the DUT presents.
module tb_axi_dma_write;
  import dma_pkg::*;

  localparam int BL          = 8;
  localparam int BURST_BYTES = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dst_addr = '0;
  logic [15:0] xfer_bursts = '0;
  logic        busy, done, error;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;

  axi_dma_write_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi_dma_write #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .dst_addr     (dst_addr),
    .xfer_bursts  (xfer_bursts),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .axi          (axi.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic [31:0] exp_aw[$];
  beat_t       exp_w[$];
  logic        exp_done[$];
  logic [1:0]  bresp_q[$];
  logic [31:0] fifo_q[$];
  logic [31:0] stash_q[$];

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int pop_cnt = 0;
  int b_owed = 0;
  bit pend_pop = 0;
  bit rnd_ready = 0;
  int awready_hold = 0;
  bit prev_aw_stall = 0;
  bit prev_w_stall = 0;
  logic [31:0] prev_awaddr = '0;
  logic [31:0] prev_wdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s got=event want=none", name);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset_n) begin
      pend_pop      = 0;
      prev_aw_stall = 0;
      prev_w_stall  = 0;
      b_owed        = 0;
    end else begin
      pend_pop = fifo_rd_en;
      check("rd_en_vs_w_handshake", fifo_rd_en, axi.wvalid && axi.wready);
      if (fifo_empty) check("wvalid_while_empty", axi.wvalid, 1'b0);
      if (prev_aw_stall) begin
        check("awvalid_hold", axi.awvalid, 1'b1);
        check("awaddr_hold", axi.awaddr, prev_awaddr);
      end
      if (prev_w_stall) begin
        check("wvalid_hold", axi.wvalid, 1'b1);
        check("wdata_hold", axi.wdata, prev_wdata);
      end
      if (axi.awvalid) begin
        check("awlen", axi.awlen, 8'd7);
        check("awsize", axi.awsize, 3'd2);
        check("awburst", axi.awburst, 2'b01);
        if (exp_aw.size() == 0) fail_now("aw_unexpected");
        else if (axi.awready) check("awaddr", axi.awaddr, exp_aw.pop_front());
      end
      prev_aw_stall = axi.awvalid && !axi.awready;
      prev_awaddr   = axi.awaddr;
      prev_w_stall  = axi.wvalid && !axi.wready;
      prev_wdata    = axi.wdata;
      if (axi.wvalid && axi.wready) begin
        beat_t e;
        hs_cnt++;
        check("wstrb", axi.wstrb, 4'hf);
        if (exp_w.size() == 0) fail_now("w_unexpected");
        else begin
          e = exp_w.pop_front();
          check("wdata", axi.wdata, e.data);
          check("wlast", axi.wlast, e.last);
        end
        if (axi.wlast) b_owed++;
      end
      if (fifo_rd_en) pop_cnt++;
      if (axi.bvalid && axi.bready) begin
        b_owed--;
        if (bresp_q.size() != 0) void'(bresp_q.pop_front());
      end
      if (done) begin
        check("busy_in_done_cycle", busy, 1'b0);
        if (exp_done.size() == 0) fail_now("done_unexpected");
        else check("error_at_done", error, exp_done.pop_front());
      end
    end
  end

  // Memory slave and FIFO model; inputs change just after the rising edge
  always @(posedge clk) begin
    #1;
    if (pend_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = fifo_empty ? $urandom : fifo_q[0];
    if (awready_hold > 0) begin
      axi.awready = 1'b0;
      awready_hold--;
    end else begin
      axi.awready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    axi.wready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    axi.bvalid = (b_owed > 0) && (rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
    axi.bresp  = (bresp_q.size() != 0) ? bresp_q[0] : AXI_RESP_OKAY;
  end

  task automatic push_words(input int k);
    for (int i = 0; i < k; i++) fifo_q.push_back(stash_q.pop_front());
  endtask

  // Expected traffic from the job rules: bursts stop after an error response.
  task automatic start_job(input logic [31:0] addr, input int n, input int err_idx, input bit load);
    int    nb;
    beat_t e;
    nb = (err_idx >= 0) ? err_idx + 1 : n;
    for (int k = 0; k < nb; k++) begin
      exp_aw.push_back(addr + 32'(k * BURST_BYTES));
      if (k == err_idx) bresp_q.push_back(($urandom_range(0, 1) == 1) ? AXI_RESP_DECERR : AXI_RESP_SLVERR);
      else              bresp_q.push_back(($urandom_range(0, 1) == 1) ? AXI_RESP_EXOKAY : AXI_RESP_OKAY);
    end
    for (int i = 0; i < nb * BL; i++) begin
      e.data = $urandom;
      e.last = ((i % BL) == BL - 1);
      exp_w.push_back(e);
      stash_q.push_back(e.data);
    end
    exp_done.push_back(err_idx >= 0);
    if (load) push_words(stash_q.size());
    dst_addr    = addr;
    xfer_bursts = 16'(n);
    start       = 1'b1;
    @(posedge clk); #2;
    start       = 1'b0;
    dst_addr    = $urandom;
    xfer_bursts = 16'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (exp_done.size() == 0 && !busy) return;
    end
    fail_now("job_timeout");
  endtask

  task automatic wait_hs(input int target, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (hs_cnt >= target) return;
      @(posedge clk); #2;
    end
    fail_now("w_beat_timeout");
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_awvalid"}, axi.awvalid, 1'b0);
    check({tag, "_wvalid"}, axi.wvalid, 1'b0);
    check({tag, "_bready"}, axi.bready, 1'b0);
    check({tag, "_rd_en"}, fifo_rd_en, 1'b0);
  endtask

  initial begin
    int          base_hs, base_pop, n, err;
    logic [31:0] a;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;

    #12;
    check_all_low("reset");
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #2;

    // two bursts, always-ready slave, plus a start pulse while busy
    start_job(32'h1000, 2, -1, 1);
    @(negedge clk);
    check("start_to_awvalid", axi.awvalid, 1'b1);
    check("busy_after_start", busy, 1'b1);
    @(posedge clk); #2;
    dst_addr = 32'hDEAD0000; xfer_bursts = 16'd5; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle(500);

    // zero-burst job
    start_job(32'h2000, 0, -1, 1);
    @(negedge clk);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_awvalid", axi.awvalid, 1'b0);
    wait_idle(20);

    // FIFO runs dry mid-burst with random wready
    rnd_ready = 1;
    base_hs = hs_cnt; base_pop = pop_cnt;
    start_job(32'h3000, 1, -1, 0);
    push_words(3);
    wait_hs(base_hs + 3, 500);
    repeat (5) @(posedge clk);
    #2;
    check("stall_beats", hs_cnt - base_hs, 3);
    push_words(5);
    wait_idle(1000);
    check("stall_handshakes", hs_cnt - base_hs, 8);
    check("stall_pops", pop_cnt - base_pop, 8);

    // awready held off
    rnd_ready = 0;
    awready_hold = 12;
    start_job(32'h4000, 1, -1, 1);
    repeat (5) @(negedge clk);
    check("aw_stalled_valid", axi.awvalid, 1'b1);
    check("aw_stalled_addr", axi.awaddr, 32'h4000);
    wait_idle(500);

    // error response on the first of three bursts, then a clearing start
    start_job(32'h5000, 3, 0, 1);
    wait_idle(500);
    @(negedge clk);
    check("error_sticky", error, 1'b1);
    @(posedge clk); #2;
    start_job(32'h6000, 1, -1, 1);
    @(negedge clk);
    check("error_cleared_by_start", error, 1'b0);
    wait_idle(500);

    // reset in the middle of the W phase
    base_hs = hs_cnt;
    start_job(32'h7000, 2, -1, 1);
    wait_hs(base_hs + 3, 500);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_all_low("midjob_reset");
    exp_aw.delete(); exp_w.delete(); exp_done.delete();
    bresp_q.delete(); fifo_q.delete(); stash_q.delete();
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #2;
    start_job(32'h8000, 1, -1, 1);
    wait_idle(500);

    // address wrap at the top of the space
    start_job(32'hFFFF_FFE0, 2, -1, 1);
    wait_idle(500);

    // randomized jobs
    rnd_ready = 1;
    for (int j = 0; j < 6; j++) begin
      a = $urandom;
      a[4:0] = 5'd0;
      n = $urandom_range(0, 3);
      err = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      start_job(a, n, err, 1);
      wait_idle(3000);
    end

    check("aw_left", exp_aw.size(), 0);
    check("w_left", exp_w.size(), 0);
    check("done_left", exp_done.size(), 0);
    check("fifo_left", fifo_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
